icache_line_refill: RTL and testbench

- Parametrised direct-mapped instruction cache for the fetch stage, with multi-word lines.
- Refills a whole line from instruction SRAM through a valid/handshake interface, so refill timing is set by memory rather than by fixed wait states.
- Delivers a two-instruction fetch window: PC and PC+4. Supports branch abort during refill and a full-cache flush.

---
 rtl/icache_line_refill.sv | 167 ++++++++++++++++
 tb/tb_icache_line_refill.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_line_refill.sv
// Direct-mapped instruction cache with multi-word lines and a two-instruction fetch window.
// Lines are refilled one word at a time over a req/ack + rvalid SRAM interface, with at most
// one request outstanding. Branch or flush aborts a refill; an already accepted request is
// drained so its response cannot land in a later refill.
// Optional macro ICACHE_PERF_EN adds perf_hit_cnt / perf_miss_cnt counters.
module icache_line_refill #(
    parameter int unsigned LINE_NUM   = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rom_addr_i,
    input  logic        rom_ce_i,
    input  logic        branch,
    input  logic        flush_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst2_o,
    output logic        inst2_valid,
    output logic        stall,
    output logic        icache_hit,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] perf_hit_cnt,
    output logic [31:0] perf_miss_cnt
`endif
);

    localparam int unsigned IDX_W  = $clog2(LINE_NUM);
    // Real offset width (0 for one-word lines); the word counter keeps at least one bit.
    localparam int unsigned WOFF_B = $clog2(LINE_WORDS);
    localparam int unsigned WOFF_W = (WOFF_B == 0) ? 1 : WOFF_B;
    localparam int unsigned TAG_W  = 32 - IDX_W - WOFF_B - 2;
    localparam int unsigned AW     = IDX_W + WOFF_B;
    localparam logic [WOFF_W-1:0] LAST_WORD = WOFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StReq, StResp, StDrain} state_e;

    state_e              state_q;
    logic [WOFF_W-1:0]   word_cnt_q;
    logic [LINE_NUM-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q  [LINE_NUM];
    logic [31:0]         data_q [LINE_NUM*LINE_WORDS];

    logic [31:0]      pc2;
    logic [TAG_W-1:0] pc_tag, pc2_tag;
    logic [IDX_W-1:0] pc_idx, pc2_idx, mem_idx;
    logic             idle, pc_hit, pc2_hit, abort, miss_start, refill_wr, refill_last;
    logic             unused_addr;

    assign pc2     = rom_addr_i + 32'd4;
    assign pc_tag  = rom_addr_i[31:AW+2];
    assign pc_idx  = rom_addr_i[AW+1:WOFF_B+2];
    assign pc2_tag = pc2[31:AW+2];
    assign pc2_idx = pc2[AW+1:WOFF_B+2];
    // mem_addr_o holds the outstanding word address for the whole refill.
    assign mem_idx = mem_addr_o[AW+1:WOFF_B+2];

    assign unused_addr = ^{rom_addr_i[1:0], pc2[1:0]};

    assign idle        = (state_q == StIdle);
    assign pc_hit      = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign pc2_hit     = valid_q[pc2_idx] && (tag_q[pc2_idx] == pc2_tag);
    assign abort       = branch || flush_i;
    assign miss_start  = idle && rom_ce_i && !pc_hit && !abort;
    assign refill_wr   = (state_q == StResp) && mem_rvalid_i && !abort;
    assign refill_last = refill_wr && (word_cnt_q == LAST_WORD);

    // Fetch-side outputs: combinational lookup, only meaningful while idle.
    always_comb begin
        icache_hit  = idle && pc_hit;
        inst_o      = icache_hit ? data_q[rom_addr_i[AW+1:2]] : 32'h0;
        inst2_valid = idle && pc2_hit && rom_ce_i && !branch;
        inst2_o     = inst2_valid ? data_q[pc2[AW+1:2]] : 32'h0;
        stall       = !idle || miss_start;
    end

    // Line storage: data words and tags need no reset, valid bits gate every use.
    always_ff @(posedge clk) begin
        if (refill_wr) begin
            data_q[mem_addr_o[AW+1:2]] <= mem_rdata_i;
        end
        if (refill_last) begin
            tag_q[mem_idx] <= mem_addr_o[31:AW+2];
        end
    end

    // Refill FSM with registered memory-side outputs and valid-bit maintenance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            word_cnt_q <= '0;
            valid_q    <= '0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= 32'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (miss_start) begin
                        state_q         <= StReq;
                        word_cnt_q      <= '0;
                        valid_q[pc_idx] <= 1'b0;
                        mem_req_o       <= 1'b1;
                        mem_addr_o      <= {rom_addr_i[31:WOFF_B+2], {(WOFF_B + 2){1'b0}}};
                    end
                end
                StReq: begin
                    if (abort) begin
                        // An accepted request still owes a response that must be swallowed.
                        mem_req_o <= 1'b0;
                        state_q   <= mem_ack_i ? StDrain : StIdle;
                    end else if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        state_q   <= StResp;
                    end
                end
                StResp: begin
                    if (abort) begin
                        state_q <= mem_rvalid_i ? StIdle : StDrain;
                    end else if (mem_rvalid_i) begin
                        if (refill_last) begin
                            valid_q[mem_idx] <= 1'b1;
                            state_q          <= StIdle;
                        end else begin
                            word_cnt_q <= word_cnt_q + 1'b1;
                            mem_addr_o <= mem_addr_o + 32'd4;
                            mem_req_o  <= 1'b1;
                            state_q    <= StReq;
                        end
                    end
                end
                StDrain: begin
                    if (mem_rvalid_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
            // Flush overrides any valid set in the same edge.
            if (flush_i) begin
                valid_q <= '0;
            end
        end
    end

`ifdef ICACHE_PERF_EN
    // Performance counters, free-running and wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_hit_cnt  <= 32'h0;
            perf_miss_cnt <= 32'h0;
        end else begin
            if (rom_ce_i && icache_hit && !branch) begin
                perf_hit_cnt <= perf_hit_cnt + 32'd1;
            end
            if (miss_start) begin
                perf_miss_cnt <= perf_miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_line_refill.sv
// Bench for icache_line_refill (LINE_NUM=32, LINE_WORDS=4): directed fetch scenarios, a
// memory responder, and a line-table model of the cache checked on every cycle.
module tb_icache_line_refill;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rom_addr_i;
    logic        rom_ce_i, branch, flush_i;
    logic [31:0] inst_o, inst2_o, mem_addr_o, mem_rdata_i;
    logic        inst2_valid, stall, icache_hit, mem_req_o, mem_ack_i, mem_rvalid_i;
`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hit_cnt, perf_miss_cnt;
`endif

    always #5 clk = ~clk;

    icache_line_refill #(
        .LINE_NUM  (32),
        .LINE_WORDS(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_addr_i  (rom_addr_i),
        .rom_ce_i    (rom_ce_i),
        .branch      (branch),
        .flush_i     (flush_i),
        .inst_o      (inst_o),
        .inst2_o     (inst2_o),
        .inst2_valid (inst2_valid),
        .stall       (stall),
        .icache_hit  (icache_hit),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i)
`ifdef ICACHE_PERF_EN
        ,
        .perf_hit_cnt (perf_hit_cnt),
        .perf_miss_cnt(perf_miss_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Next-cycle stimulus, applied just after each rising edge.
    logic        nx_rst = 1'b1;
    logic [31:0] nx_addr = 32'h0;
    logic        nx_ce = 1'b0, nx_br = 1'b0, nx_fl = 1'b0;

    // Memory responder: one outstanding read, data = address ^ 0xA5A5A5A5.
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    bit          cap_acc = 1'b0, cap_del = 1'b0;
    logic [31:0] cap_addr = 32'h0;
    bit          ack_hold = 1'b0, rv_hold = 1'b0;
    logic [31:0] acc_q[$];

    // Model: which line base each index holds, plus the progress of the current refill.
    bit          m_ok   [32];
    logic [31:0] m_base [32];
    bit          busy = 1'b0, asking = 1'b0, owed = 1'b0, dumping = 1'b0;
    logic [31:0] r_base = 32'h0;
    int          k = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a & ~32'h3) ^ 32'hA5A5A5A5;
    endfunction

    function automatic logic [4:0] lidx(input logic [31:0] a);
        logic [31:0] t;
        t = (a >> 4) % 32;
        return t[4:0];
    endfunction

    function automatic bit mhit(input logic [31:0] a);
        return m_ok[lidx(a)] && (m_base[lidx(a)] == (a & ~32'hF));
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_ok[i]) m_ok[i] = 1'b0;
        busy = 1'b0; asking = 1'b0; owed = 1'b0; dumping = 1'b0; k = 0;
    endtask

    task automatic compare_and_advance();
        bit          idle, h, miss_now, v2, abort;
        logic [31:0] pc, pc2;
        if (rst) begin
            chk("rst_inst_o", inst_o, 0);
            chk("rst_inst2_o", inst2_o, 0);
            chk("rst_inst2_valid", 32'(inst2_valid), 0);
            chk("rst_stall", 32'(stall), 0);
            chk("rst_hit", 32'(icache_hit), 0);
            chk("rst_mem_req", 32'(mem_req_o), 0);
            chk("rst_mem_addr", mem_addr_o, 0);
            model_reset();
        end else begin
            pc       = rom_addr_i;
            pc2      = pc + 32'd4;
            abort    = branch || flush_i;
            idle     = !busy && !dumping;
            h        = idle && mhit(pc);
            miss_now = idle && rom_ce_i && !mhit(pc) && !abort;
            v2       = idle && mhit(pc2) && rom_ce_i && !branch;
            chk("hit", 32'(icache_hit), 32'(h));
            chk("inst_o", inst_o, h ? memf(pc) : 32'h0);
            chk("inst2_valid", 32'(inst2_valid), 32'(v2));
            chk("inst2_o", inst2_o, v2 ? memf(pc2) : 32'h0);
            chk("stall", 32'(stall), 32'(busy || dumping || miss_now));
            chk("mem_req", 32'(mem_req_o), 32'(asking));
            if (asking) chk("mem_addr", mem_addr_o, r_base + 32'(k) * 4);
            // Advance to the state after the coming edge.
            if (idle) begin
                if (miss_now) begin
                    busy = 1'b1; asking = 1'b1; k = 0;
                    r_base = pc & ~32'hF;
                    m_ok[lidx(pc)] = 1'b0;
                end
            end else if (dumping) begin
                if (mem_rvalid_i) dumping = 1'b0;
            end else if (asking) begin
                if (abort) begin
                    asking = 1'b0; busy = 1'b0; dumping = mem_ack_i;
                end else if (mem_ack_i) begin
                    asking = 1'b0; owed = 1'b1;
                end
            end else begin
                if (abort) begin
                    owed = 1'b0; busy = 1'b0; dumping = !mem_rvalid_i;
                end else if (mem_rvalid_i) begin
                    owed = 1'b0;
                    k++;
                    if (k == 4) begin
                        busy = 1'b0;
                        m_ok[lidx(r_base)]   = 1'b1;
                        m_base[lidx(r_base)] = r_base;
                    end else begin
                        asking = 1'b1;
                    end
                end
            end
            if (flush_i) foreach (m_ok[i]) m_ok[i] = 1'b0;
        end
        cap_acc  = mem_req_o && mem_ack_i;
        cap_del  = mem_rvalid_i;
        cap_addr = mem_addr_o;
        if (cap_acc) acc_q.push_back(mem_addr_o);
    endtask

    // One clock: drive after the rising edge, check on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        rst        = nx_rst;
        rom_addr_i = nx_addr;
        rom_ce_i   = nx_ce;
        branch     = nx_br;
        flush_i    = nx_fl;
        if (cap_del) pend = 1'b0;
        if (cap_acc) begin
            pend      = 1'b1;
            pend_addr = cap_addr;
        end
        #1;
        mem_ack_i    = mem_req_o && !ack_hold;
        mem_rvalid_i = pend && !rv_hold;
        mem_rdata_i  = mem_rvalid_i ? memf(pend_addr) : 32'h0;
        @(negedge clk);
        compare_and_advance();
    endtask

    task automatic fetch(input logic [31:0] a, input logic ce);
        nx_addr = a; nx_ce = ce; nx_br = 1'b0; nx_fl = 1'b0;
    endtask

    task automatic run_until_idle(input string name);
        int n;
        n = 0;
        while (stall && n < 80) begin
            step();
            n++;
        end
        chk(name, 32'(stall), 0);
    endtask

    logic [31:0] exp_addrs [4];
    int          n;

    initial begin
        rst = 1'b1; rom_addr_i = 32'h0; rom_ce_i = 1'b0; branch = 1'b0; flush_i = 1'b0;
        mem_ack_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        model_reset();
        exp_addrs[0] = 32'h80000010; exp_addrs[1] = 32'h80000014;
        exp_addrs[2] = 32'h80000018; exp_addrs[3] = 32'h8000001C;

        step(); step();
        nx_rst = 1'b0;
        step();
        chk("post_rst_mem_addr", mem_addr_o, 32'h0);
        chk("post_rst_stall", 32'(stall), 0);

        // Cold miss: four word requests, nine stall cycles, then a hit.
        acc_q.delete();
        fetch(32'h80000010, 1'b1);
        step();
        n = 0;
        while (stall && n < 60) begin
            n++;
            step();
        end
        chk("cold_stall_cycles", n, 9);
        chk("cold_hit", 32'(icache_hit), 1);
        chk("cold_inst", inst_o, 32'h25A5A5B5);
        chk("cold_nreq", acc_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("cold_addr", (i < acc_q.size()) ? acc_q[i] : 32'hFFFFFFFF, exp_addrs[i]);
        end

        // Two-wide window inside the line and at the line end.
        fetch(32'h80000014, 1'b1);
        step();
        chk("win_inst", inst_o, 32'h25A5A5B1);
        chk("win_inst2", inst2_o, 32'h25A5A5BD);
        chk("win_inst2_valid", 32'(inst2_valid), 1);
        fetch(32'h8000001C, 1'b1);
        step();
        chk("end_hit", 32'(icache_hit), 1);
        chk("end_inst2_valid", 32'(inst2_valid), 0);

        // Fill the next line; the window now spans both lines.
        fetch(32'h80000020, 1'b1);
        step();
        run_until_idle("fill2_done");
        fetch(32'h8000001C, 1'b1);
        step();
        chk("span_inst2_valid", 32'(inst2_valid), 1);
        chk("span_inst2", inst2_o, 32'h25A5A585);

        // Flush invalidates both lines.
        nx_fl = 1'b1; nx_ce = 1'b0;
        step();
        fetch(32'h80000020, 1'b0);
        step();
        chk("flush_miss_b", 32'(icache_hit), 0);
        fetch(32'h80000010, 1'b1);
        step();
        chk("flush_miss_a", 32'(icache_hit), 0);
        chk("flush_stall", 32'(stall), 1);
        step();
        chk("flush_req", 32'(mem_req_o), 1);
        chk("flush_req_addr", mem_addr_o, 32'h80000010);

        // Branch in RESP while word 2 is outstanding -> drain, then refetch from the base.
        n = 0;
        while (!(acc_q.size() > 0 && acc_q[$] == 32'h80000018) && n < 40) begin
            step();
            n++;
        end
        chk("br_word2_accepted", (acc_q.size() > 0) ? acc_q[$] : 32'h0, 32'h80000018);
        rv_hold = 1'b1;
        nx_br = 1'b1;
        step();
        chk("br_resp_stall", 32'(stall), 1);
        nx_br = 1'b0; nx_ce = 1'b0;
        step();
        chk("drain_stall", 32'(stall), 1);
        chk("drain_no_req", 32'(mem_req_o), 0);
        step();
        chk("drain_hold", 32'(stall), 1);
        rv_hold = 1'b0;
        step();
        step();
        chk("drain_exit", 32'(stall), 0);
        acc_q.delete();
        fetch(32'h80000010, 1'b1);
        step();
        chk("refetch_miss", 32'(icache_hit), 0);
        step();
        chk("refetch_addr", mem_addr_o, 32'h80000010);
        run_until_idle("refetch_done");
        chk("refetch_hit", 32'(icache_hit), 1);

        // Branch in REQ with no ack withdraws the request.
        ack_hold = 1'b1;
        fetch(32'h80000100, 1'b1);
        step();
        step();
        chk("req_wait", 32'(mem_req_o), 1);
        nx_br = 1'b1;
        step();
        fetch(32'h80000100, 1'b0);
        step();
        chk("req_abort_req", 32'(mem_req_o), 0);
        chk("req_abort_stall", 32'(stall), 0);
        chk("req_abort_inval", 32'(icache_hit), 0);
        ack_hold = 1'b0;

        // Alias: same index, different tag evicts.
        fetch(32'h80000000, 1'b1);
        step();
        run_until_idle("alias_fill_a");
        chk("alias_hit_a", 32'(icache_hit), 1);
        fetch(32'h80000200, 1'b1);
        step();
        chk("alias_miss_b", 32'(icache_hit), 0);
        run_until_idle("alias_fill_b");
        fetch(32'h80000000, 1'b0);
        step();
        chk("alias_evict_a", 32'(icache_hit), 0);

        // Reset mid-refill; the late response arrives while idle and is ignored.
        rv_hold = 1'b1;
        fetch(32'h80000300, 1'b1);
        step(); step(); step();
        nx_rst = 1'b1; nx_ce = 1'b0;
        step();
        chk("midrst_req", 32'(mem_req_o), 0);
        nx_rst = 1'b0;
        rv_hold = 1'b0;
        step();
        step();
        fetch(32'h80000300, 1'b0);
        step();
        chk("late_rvalid_ignored", 32'(icache_hit), 0);
        chk("late_rvalid_idle", 32'(stall), 0);

`ifdef ICACHE_PERF_EN
        nx_rst = 1'b1; nx_ce = 1'b0;
        step();
        nx_rst = 1'b0;
        step();
        fetch(32'h80000040, 1'b1);
        step();
        run_until_idle("perf_fill");
        step();
        step();
        nx_ce = 1'b0;
        step();
        chk("perf_miss", perf_miss_cnt, 1);
        chk("perf_hit", perf_hit_cnt, 3);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
